mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single-ported unified memory between the fetch stage (instruction port) and the memory stage (load/store port) of the multi-cycle RISC-V core. It grants one transaction at a time, drives the memory port, tracks the fixed memory latency, and returns each response to the requester that owns it. Ties between the two ports are settled by alternating priority, with the load/store port winning the first tie after reset. The block also supports squashing in-flight fetches on a branch redirect and keeps a saturating conflict counter for performance analysis.

## Interface
- LATENCY, 2, memory read latency in cycles, legal range 1..15
- AW, 32, address width
- CNT_W, 16, width of the conflict counter
- clk  in  1  clock; all state is updated on the rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request, level-sensitive
- i_addr  in  AW  fetch address
- i_flush  in  1  fetch redirect (branch correction or jump)
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  one-cycle pulse: i_rdata is valid
- i_rdata  out  32  fetched instruction
- d_req  in  1  load/store request, level-sensitive
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  32  store data
- d_be  in  4  store byte enables
- d_gnt  out  1  load/store request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data valid or store acknowledged
- d_rdata  out  32  load data; 0 for a store acknowledge
- mem_en, mem_we  out  1 each  memory strobe and write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_rdata  in  32  memory read data, valid LATENCY cycles after the mem_en cycle
- busy  out  1  a transaction is in flight
- conflict_cnt  out  CNT_W  count of cycles in which a request was denied because both ports requested

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY: a transaction is in flight. The owner register (I or D) and a latency counter are valid.
- Grants:
  - Grants are issued only in IDLE. Each grant is combinational from the registered state and the current requests.
  - Grant with mem_en=1 in the same cycle, with the address, data, byte enables and write enable of the winning port muxed onto the memory port.
- Arbitration in IDLE:
  - Single requester: that port is granted.
  - Both requesting: the port that was not granted last time wins, per the last_owner register.
  - last_owner resets to I, so D wins the first tie.
- Flush:
  - i_flush=1 in IDLE blocks a fetch grant in that cycle. A pending d_req can still be granted in that cycle.
  - i_flush=1 while a fetch is in flight sets a squash flag. The memory transaction still runs to completion, but i_rvalid is suppressed.
  - The squash flag clears when that transaction completes.
- Writes use the same latency as reads. d_rvalid pulses at completion with d_rdata=0.
- Requesters change their address and data only in a cycle after their grant. The arbiter does not register request payloads.
- conflict_cnt increments in every IDLE cycle in which i_req and d_req are both high and i_flush=0. The counter saturates at all ones.
- Reset (rst=0, at any time, including mid-transaction):
  - Outputs go to 0: i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy, conflict_cnt.
  - Internal state: state=IDLE, last_owner=I, squash=0.
  - The in-flight transaction is dropped and produces no response after reset is released.
  - The grants are forced to 0 while rst=0.

## Timing
- A grant in cycle T moves the block to BUSY at T+1. busy=1 during T+1..T+LATENCY-1.
- The response pulse (rvalid, with the rdata register loaded from mem_rdata) appears in cycle T+LATENCY.
- In cycle T+LATENCY the state is IDLE, so a new grant in that same cycle is legal.
- Peak throughput is one transaction per LATENCY cycles.
- With LATENCY=1, BUSY is never entered. The response arrives at T+1, and a grant is possible every cycle.
- Request-to-grant latency is 0 cycles when uncontended. A losing requester waits at most one transaction (LATENCY cycles).
- i_rdata and d_rdata hold their last value between pulses.

## Test plan
- After reset, i_req=1 with i_addr=0x0000_0040 and mem_rdata=0x0000_0013 at T+2 (LATENCY=2) -> i_gnt=1 and mem_en=1 at T, i_rvalid=1 and i_rdata=0x13 at T+2, busy=1 at T+1.
- i_req and d_req both held high from reset release -> grants go D, I, D, I in cycles T, T+2, T+4, T+6, and conflict_cnt=4 at T+7.
- Store with d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF -> at grant, mem_we=1, mem_wdata=0xDEADBEEF, mem_be=0xF; at T+2, d_rvalid=1 and d_rdata=0.
- Fetch granted at T with i_flush=1 at T+1 -> no i_rvalid at T+2. A d_req waiting since T+1 is granted at T+2.
- rst driven low at T+1 during a load -> all outputs 0 immediately, no d_rvalid after release, and the first tie after release goes to D.
- LATENCY=1 with i_req held high -> i_gnt every cycle and i_rvalid every cycle from T+1.
- conflict_cnt preloaded near saturation (CNT_W=4) with 20 contested cycles -> conflict_cnt holds 0xF.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between the fetch port and the
// load/store port, tracks the fixed read latency and routes each response home.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [AW-1:0]    i_addr,
    input  logic             i_flush,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [AW-1:0]    d_addr,
    input  logic [31:0]      d_wdata,
    input  logic [3:0]       d_be,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [AW-1:0]    mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [31:0]      mem_rdata,
    output logic             busy,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    // BUSY lasts LATENCY-1 cycles; the counter counts down to the last one.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t           r_state, w_state_nxt;
    owner_t           r_owner, w_owner_nxt;
    owner_t           r_last_owner, w_last_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic             r_squash, w_squash_nxt;
    logic             r_we, w_we_nxt;
    logic [31:0]      r_i_rdata, r_d_rdata;
    logic [CNT_W-1:0] r_conflict;

    logic             w_idle, w_i_elig, w_d_elig, w_tie;
    logic             w_gnt_i, w_gnt_d, w_conflict;
    logic             w_i_rvalid, w_d_rvalid;
    logic [31:0]      w_d_resp;

    // Grants are combinational from registered state and are held off in reset.
    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_i_elig   = w_idle & i_req & ~i_flush & rst;
        w_d_elig   = w_idle & d_req & rst;
        w_tie      = w_i_elig & w_d_elig;
        w_gnt_d    = w_d_elig & (~w_tie | (r_last_owner == OWN_I));
        w_gnt_i    = w_i_elig & (~w_tie | (r_last_owner == OWN_D));
        w_conflict = w_idle & i_req & d_req & ~i_flush;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_last_nxt   = r_last_owner;
        w_cnt_nxt    = r_cnt;
        w_we_nxt     = r_we;
        w_done_nxt   = 1'b0;
        w_squash_nxt = r_done ? 1'b0 : r_squash;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt_i | w_gnt_d) begin
                    w_owner_nxt = w_gnt_d ? OWN_D : OWN_I;
                    w_last_nxt  = w_gnt_d ? OWN_D : OWN_I;
                    w_we_nxt    = w_gnt_d & d_we;
                    if (LATENCY == 1) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = CNT_INIT;
                    end
                end
            end
            ST_BUSY: begin
                if ((r_owner == OWN_I) && i_flush)
                    w_squash_nxt = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_last_owner <= OWN_I;
            r_cnt        <= '0;
            r_done       <= 1'b0;
            r_squash     <= 1'b0;
            r_we         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
            r_cnt        <= w_cnt_nxt;
            r_done       <= w_done_nxt;
            r_squash     <= w_squash_nxt;
            r_we         <= w_we_nxt;
        end
    end

    // Response data passes straight through in the pulse cycle and is held after.
    always_comb begin
        w_i_rvalid = r_done & (r_owner == OWN_I) & ~r_squash;
        w_d_rvalid = r_done & (r_owner == OWN_D);
        w_d_resp   = r_we ? '0 : mem_rdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
            r_conflict <= '0;
        end else begin
            if (w_i_rvalid)
                r_i_rdata <= mem_rdata;
            if (w_d_rvalid)
                r_d_rdata <= w_d_resp;
            if (w_conflict && (r_conflict != '1))
                r_conflict <= r_conflict + 1'b1;
        end
    end

    always_comb begin
        i_gnt        = w_gnt_i;
        d_gnt        = w_gnt_d;
        mem_en       = w_gnt_i | w_gnt_d;
        mem_we       = w_gnt_d & d_we;
        mem_addr     = w_gnt_d ? d_addr : (w_gnt_i ? i_addr : '0);
        mem_wdata    = w_gnt_d ? d_wdata : '0;
        mem_be       = w_gnt_d ? d_be : (w_gnt_i ? 4'hF : 4'h0);
        i_rvalid     = w_i_rvalid;
        d_rvalid     = w_d_rvalid;
        i_rdata      = w_i_rvalid ? mem_rdata : r_i_rdata;
        d_rdata      = w_d_rvalid ? w_d_resp : r_d_rdata;
        busy         = (r_state == ST_BUSY);
        conflict_cnt = r_conflict;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one LATENCY=2 instance for the main protocol and one
// LATENCY=1 / 4-bit-counter instance for back-to-back grants and saturation.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;

    logic        i_req, i_flush, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [15:0] conflict_cnt;

    logic        b_i_req, b_d_req;
    logic [31:0] b_mem_rdata;
    logic        b_i_gnt, b_i_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_i_rdata, b_d_rdata, b_mem_addr, b_mem_wdata;
    logic [3:0]  b_mem_be;
    logic [3:0]  b_conflict_cnt;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    mem_port_arbiter #(.LATENCY(2), .AW(32), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .busy(busy), .conflict_cnt(conflict_cnt)
    );

    mem_port_arbiter #(.LATENCY(1), .AW(32), .CNT_W(4)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .i_req(b_i_req), .i_addr(32'h0000_0000), .i_flush(1'b0),
        .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(1'b0), .d_addr(32'h0000_0400), .d_wdata(32'h0),
        .d_be(4'hF),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
        .busy(b_busy), .conflict_cnt(b_conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        i_req = 0; i_flush = 0; i_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_rdata = '0; b_i_req = 0; b_d_req = 0; b_mem_rdata = '0;

        // Reset: grants held off even with both requests high.
        #2; i_req = 1; d_req = 1; #1;
        chk("rst_i_gnt", {31'b0, i_gnt}, 0);
        chk("rst_d_gnt", {31'b0, d_gnt}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_conflict", {16'b0, conflict_cnt}, 0);
        i_req = 0; d_req = 0;
        tick(); tick(); rst = 1'b1;

        // Single fetch.
        i_req = 1; i_addr = 32'h0000_0040; #1;
        chk("f_i_gnt", {31'b0, i_gnt}, 1);
        chk("f_mem_en", {31'b0, mem_en}, 1);
        chk("f_mem_addr", mem_addr, 32'h40);
        chk("f_mem_we", {31'b0, mem_we}, 0);
        tick(); i_req = 0; #1;
        chk("f_busy", {31'b0, busy}, 1);
        chk("f_busy_no_en", {31'b0, mem_en}, 0);
        tick(); mem_rdata = 32'h0000_0013; #1;
        chk("f_rvalid", {31'b0, i_rvalid}, 1);
        chk("f_rdata", i_rdata, 32'h13);
        chk("f_idle", {31'b0, busy}, 0);
        chk("f_no_d_rvalid", {31'b0, d_rvalid}, 0);
        tick(); mem_rdata = 32'hFFFF_FFFF; #1;
        chk("f_rvalid_pulse", {31'b0, i_rvalid}, 0);
        chk("f_rdata_hold", i_rdata, 32'h13);

        // Store.
        tick(); d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF; #1;
        chk("s_d_gnt", {31'b0, d_gnt}, 1);
        chk("s_mem_we", {31'b0, mem_we}, 1);
        chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("s_mem_be", {28'b0, mem_be}, 32'hF);
        chk("s_mem_addr", mem_addr, 32'h100);
        tick(); d_req = 0; d_we = 0; #1;
        chk("s_busy", {31'b0, busy}, 1);
        tick(); mem_rdata = 32'h0000_0055; #1;
        chk("s_rvalid", {31'b0, d_rvalid}, 1);
        chk("s_rdata_zero", d_rdata, 0);

        // Fetch squashed by a redirect while in flight; waiting load follows.
        tick(); i_req = 1; i_addr = 32'h80; #1;
        chk("q_i_gnt", {31'b0, i_gnt}, 1);
        tick(); i_req = 0; i_flush = 1; d_req = 1; d_addr = 32'h200; #1;
        chk("q_d_wait", {31'b0, d_gnt}, 0);
        tick(); i_flush = 0; mem_rdata = 32'h77; #1;
        chk("q_no_rvalid", {31'b0, i_rvalid}, 0);
        chk("q_rdata_kept", i_rdata, 32'h13);
        chk("q_d_gnt", {31'b0, d_gnt}, 1);
        chk("q_d_addr", mem_addr, 32'h200);
        tick(); d_req = 0; #1;
        tick(); mem_rdata = 32'h1234; #1;
        chk("q_d_rvalid", {31'b0, d_rvalid}, 1);
        chk("q_d_rdata", d_rdata, 32'h1234);

        // Redirect in IDLE blocks the fetch grant for that cycle only.
        tick(); i_req = 1; i_flush = 1; #1;
        chk("fi_blocked", {31'b0, i_gnt}, 0);
        chk("fi_no_en", {31'b0, mem_en}, 0);
        tick(); i_flush = 0; #1;
        chk("fi_gnt", {31'b0, i_gnt}, 1);
        tick(); i_req = 0; #1;
        tick(); mem_rdata = 32'hCAFE; #1;
        chk("fi_rvalid", {31'b0, i_rvalid}, 1);

        // Reset during a load, then release with both ports requesting.
        tick(); d_req = 1; d_addr = 32'h300; #1;
        chk("r_d_gnt", {31'b0, d_gnt}, 1);
        tick(); rst = 0; i_req = 1; d_req = 1; #1;
        chk("r_d_gnt0", {31'b0, d_gnt}, 0);
        chk("r_i_gnt0", {31'b0, i_gnt}, 0);
        chk("r_mem_en0", {31'b0, mem_en}, 0);
        chk("r_mem_addr0", mem_addr, 0);
        chk("r_busy0", {31'b0, busy}, 0);
        chk("r_i_rdata0", i_rdata, 0);
        chk("r_d_rdata0", d_rdata, 0);
        tick(); mem_rdata = 32'hAA; #1;
        chk("r_no_rvalid", {31'b0, d_rvalid}, 0);
        tick(); rst = 1; #1;
        chk("t0_no_rvalid", {31'b0, d_rvalid}, 0);
        chk("t0_d_wins", {31'b0, d_gnt}, 1);
        chk("t0_i_loses", {31'b0, i_gnt}, 0);
        tick(); #1;
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_no_rvalid", {31'b0, d_rvalid}, 0);
        tick(); #1;
        chk("t2_i_gnt", {31'b0, i_gnt}, 1);
        chk("t2_d_gnt", {31'b0, d_gnt}, 0);
        chk("t2_d_rvalid", {31'b0, d_rvalid}, 1);
        tick(); tick(); #1;
        chk("t4_d_gnt", {31'b0, d_gnt}, 1);
        tick(); tick(); #1;
        chk("t6_i_gnt", {31'b0, i_gnt}, 1);
        tick(); #1;
        chk("t7_conflict", {16'b0, conflict_cnt}, 4);
        i_req = 0; d_req = 0;
        tick(); tick();

        // LATENCY=1: a fetch grant every cycle, response the next cycle.
        b_i_req = 1; #1;
        chk("l1_gnt0", {31'b0, b_i_gnt}, 1);
        chk("l1_rvalid0", {31'b0, b_i_rvalid}, 0);
        chk("l1_busy0", {31'b0, b_busy}, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(); b_mem_rdata = 32'h1000 + k; #1;
            chk("l1_gnt", {31'b0, b_i_gnt}, 1);
            chk("l1_rvalid", {31'b0, b_i_rvalid}, 1);
            chk("l1_rdata", b_i_rdata, 32'h1000 + k);
        end

        // Contested every cycle: alternation, then 4-bit saturation.
        tick(); b_d_req = 1; #1;
        chk("l1_c1_d", {31'b0, b_d_gnt}, 1);
        chk("l1_c1_i", {31'b0, b_i_gnt}, 0);
        tick(); #1;
        chk("l1_c2_i", {31'b0, b_i_gnt}, 1);
        chk("l1_c2_drv", {31'b0, b_d_rvalid}, 1);
        chk("l1_c2_cnt", {28'b0, b_conflict_cnt}, 1);
        for (int k = 3; k <= 21; k++) begin
            tick(); #1;
            if (k == 15) chk("l1_cnt14", {28'b0, b_conflict_cnt}, 14);
        end
        chk("l1_cnt_sat", {28'b0, b_conflict_cnt}, 15);
        b_i_req = 0; b_d_req = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
